// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// One shared 2*XLEN accumulator runs a radix-2 shift-add multiply or a
// restoring divide on operand magnitudes. Signs are fixed up afterwards.
// The latency is fixed at XLEN iterations, with no early exit.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r;
    logic [2:0]           op_r;
    logic [4:0]           rd_r;
    logic [XLEN-1:0]      a_mag_r, b_mag_r;
    logic                 neg_r, rem_neg_r, b_zero_r;
    logic [2*XLEN-1:0]    acc_r, acc_next_s;
    logic [XLEN-1:0]      result_r, fix_result_s;
    logic [4:0]           rd_out_r;
    logic                 busy_r, done_r;

    // Accept-time operand decode. Only MULHSU mixes signedness.
    logic                 signed_a_s, signed_b_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]      a_mag_s, b_mag_s;

    // Iteration and fix-up intermediates.
    logic [XLEN:0]        mul_sum_s, div_shift_s;
    logic [XLEN-1:0]      div_rem_s;
    logic [2*XLEN-1:0]    prod_s;
    logic [XLEN-1:0]      quo_s, rem_s;

    // Operand sign flags and magnitudes. 0x80000000 becomes unsigned 2^31.
    always_comb begin
        signed_a_s = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                     (op == 3'b100) || (op == 3'b110);
        signed_b_s = (op == 3'b000) || (op == 3'b001) ||
                     (op == 3'b100) || (op == 3'b110);
        a_neg_s    = signed_a_s && rs1_data[XLEN-1];
        b_neg_s    = signed_b_s && rs2_data[XLEN-1];
        if (a_neg_s) begin
            a_mag_s = -rs1_data;
        end else begin
            a_mag_s = rs1_data;
        end
        if (b_neg_s) begin
            b_mag_s = -rs2_data;
        end else begin
            b_mag_s = rs2_data;
        end
    end

    // One multiply (shift-add) or divide (restoring) step on the accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                      (acc_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_rem_s   = XLEN'(div_shift_s - {1'b0, b_mag_r});
        if (op_r[2]) begin
            if (div_shift_s >= {1'b0, b_mag_r}) begin
                acc_next_s = {div_rem_s, acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign correction and half/quotient/remainder selection.
    // The division-by-zero quotient is forced to all ones.
    always_comb begin
        prod_s = neg_r ? -acc_r : acc_r;
        if (b_zero_r) begin
            quo_s = {XLEN{1'b1}};
        end else if (neg_r) begin
            quo_s = -acc_r[XLEN-1:0];
        end else begin
            quo_s = acc_r[XLEN-1:0];
        end
        rem_s = rem_neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            3'b000:                 fix_result_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result_s = quo_s;
            3'b110, 3'b111:         fix_result_s = rem_s;
            default:                fix_result_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic. start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = start ? S_CALC : S_IDLE;
            S_CALC:  state_s = (cnt_r == CW'(XLEN-1)) ? S_FIX : S_CALC;
            S_FIX:   state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_CALC) || (state_s == S_FIX);
            done_r  <= (state_s == S_DONE);
        end
    end

    // Datapath: latch operands at accept, iterate in CALC, register result in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            op_r      <= 3'b000;
            rd_r      <= 5'd0;
            a_mag_r   <= {XLEN{1'b0}};
            b_mag_r   <= {XLEN{1'b0}};
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
            b_zero_r  <= 1'b0;
            acc_r     <= {(2*XLEN){1'b0}};
            result_r  <= {XLEN{1'b0}};
            rd_out_r  <= 5'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r      <= op;
                        rd_r      <= rd_in;
                        a_mag_r   <= a_mag_s;
                        b_mag_r   <= b_mag_s;
                        neg_r     <= a_neg_s ^ b_neg_s;
                        rem_neg_r <= a_neg_s;
                        b_zero_r  <= (rs2_data == {XLEN{1'b0}});
                        cnt_r     <= {CW{1'b0}};
                        acc_r     <= op[2] ? {{XLEN{1'b0}}, a_mag_s}
                                           : {{XLEN{1'b0}}, b_mag_s};
                    end
                end
                S_CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                S_FIX: begin
                    result_r <= fix_result_s;
                    rd_out_r <= rd_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign rd_out = rd_out_r;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit sitting directly downstream of the register file.
- Consumes the two register read operands plus destination register number; produces a 32-bit result and destination tag for register write-back.
- Fixed-latency radix-2 shift-add multiplier and restoring divider share one datapath, under a start/busy/done handshake.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- start  input  1  request; sampled only when busy=0
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  XLEN  operand A (dividend / multiplicand)
- rs2_data  input  XLEN  operand B (divisor / multiplier)
- rd_in  input  5  destination register number
- busy  output  1  operation in progress; start is ignored while high
- done  output  1  one-cycle pulse; result and rd_out valid in that cycle
- result  output  XLEN  operation result
- rd_out  output  5  destination register captured at start

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: state=IDLE, busy=0, done=0, result=0, rd_out=0, internal accumulators=0.
  - rst asserted mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: start=1 latches op, rd_in, and magnitudes/sign flags of operands. Next state is CALC with counter=0 and busy=1.
  - CALC: one iteration per cycle. Leaves to FIX after counter reaches XLEN-1, i.e. exactly XLEN cycles.
  - FIX: applies sign correction and selects the high or low half (mul) or quotient/remainder (div). Registers result; next state is DONE.
  - DONE: done=1, busy=0 for one cycle; next state is IDLE. start is not accepted in DONE.
- Latency and handshake:
  - start sampled at edge E0.
  - busy high from cycle after E0 through FIX (XLEN+1 cycles).
  - done high in cycle XLEN+2 after E0 (34 for XLEN=32).
  - Next start accepted at the edge ending the first IDLE cycle after DONE; back-to-back throughput is one op per XLEN+3 cycles.
  - result and rd_out hold their values after done until the next FIX.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are computed at accept. The 2XLEN-bit product is negated in FIX if the signs differ.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Division:
  - Restoring, on magnitudes.
  - Quotient is negated if operand signs differ (signed ops).
  - Remainder takes the sign of the dividend.
- Boundary cases (computed with the same fixed latency, no early exit):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1_data.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Operand 0x80000000 magnitude is handled as unsigned 2^31 (no overflow in the magnitude path).
- Input changes on rs1_data/rs2_data/op/rd_in after acceptance have no effect.
- start=1 while busy=1 or during DONE is dropped silently; the upstream controller must hold start until it sees busy=0 in IDLE.

Test Plan:
- Reset then MUL, rs1=7, rs2=6, rd_in=5 -> busy=1 for 33 cycles; done pulse at cycle 34; result=42, rd_out=5.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. REMU -> 1.
- Divide by zero: DIV 13/0 -> 0xFFFFFFFF. REMU 13/0 -> 13. Overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Latency is still 34 cycles.
- start pulsed at cycle 10 of a running op with different operands -> ignored; first result unchanged; no second done.
- rst asserted at cycle 20 of an operation -> busy=0, done never pulses, result=0. A new MUL 3×3 started after reset -> 9.
